layer_tile_sequencer: RTL and testbench
=======================================

# layer_tile_sequencer

Command-driven scheduler that sits above the layering pipeline controller and runs a whole network pass on the systolic array. It accepts one command of (layers × tiles per layer) from the host, issues one start pulse per tile, waits for each tile to finish, and flips the weight ping-pong buffer select at every layer boundary. It also reports progress and detects a pipeline controller that never acknowledges a start.

## Interface
- LAYER_W, 4: width of the layer count and layer index.
- TILE_W, 8: width of the tile count and tile index.
- ACK_TIMEOUT, 4: cycles allowed in WAIT_ACK before an error is declared (≥1).

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  high only in IDLE.
- cmd_layers  in  LAYER_W  number of layers; 0 is illegal.
- cmd_tiles  in  TILE_W  tiles per layer; 0 is illegal.
- abort  in  1  cancels the current command.
- pipe_start  out  1  one-cycle start pulse to the pipeline controller.
- pipe_busy  in  1  busy from the pipeline controller.
- buf_sel  out  1  weight ping-pong select: 0 for even layers, 1 for odd layers.
- layer_idx  out  LAYER_W  current layer.
- tile_idx  out  TILE_W  current tile within the layer.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes normally.
- err  out  1  one-cycle pulse on an illegal command or an ack timeout.

## Operation
- States:
  - IDLE, ISSUE, WAIT_ACK, WAIT_DONE, ADVANCE, DONE.
  - The state register is 3 bits.
  - Unused encodings go to IDLE.
- IDLE:
  - cmd_ready=1. A handshake occurs when cmd_valid=1.
  - If cmd_layers==0 or cmd_tiles==0: err pulses next cycle and the block stays in IDLE.
  - Otherwise: latch both counts, clear layer_idx, tile_idx and buf_sel, and go to ISSUE.
- ISSUE: pipe_start = (state==ISSUE) && !abort. Always goes to WAIT_ACK.
- WAIT_ACK:
  - Clear the ack counter on entry.
  - pipe_busy=1 → WAIT_DONE.
  - Otherwise the counter increments. Once ACK_TIMEOUT cycles have passed in this state without pipe_busy, err pulses and the block goes to IDLE.
- WAIT_DONE: pipe_busy=0 → ADVANCE.
- ADVANCE:
  - tile_idx < tiles−1: tile_idx+1, then ISSUE.
  - Last tile, layer_idx < layers−1: tile_idx=0, layer_idx+1, toggle buf_sel, then ISSUE.
  - Last tile of last layer: DONE.
- DONE: done=1 for this cycle, then IDLE. layer_idx, tile_idx and buf_sel hold their final values until the next accepted command.
- abort:
  - In any non-IDLE state, abort=1 forces IDLE on the next edge.
  - No done and no err. pipe_start is suppressed in that cycle.
  - abort is ignored in IDLE.
- Index arithmetic is unsigned and never wraps, because bounds are checked before each increment.
- cmd_valid outside IDLE is ignored (cmd_ready=0). No queuing.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1.
  - pipe_start, busy, done, err, buf_sel = 0.
  - layer_idx, tile_idx = 0; ack counter = 0.
- Counted from the accept cycle 0:
  - ISSUE at cycle 1.
  - With the standard pipeline controller (busy high for the 8 cycles after the start cycle), one tile takes 11 cycles: ISSUE, WAIT_ACK, 8×WAIT_DONE, ADVANCE.
  - pipe_start pulses at cycles 1+11k.
  - done at cycle 1+11·L·T.
  - cmd_ready is high again at cycle 2+11·L·T.
- With an arbitrary controller, each tile costs 3 + ack-wait + busy-duration cycles.
- buf_sel toggles in the cycle after the ADVANCE that crosses a layer boundary, so it is stable before the next pipe_start.
- done and err are never high together. err has a 1-cycle latency from its cause.
- rst mid-command behaves exactly like reset from power-up. pipe_start drops in the same cycle that rst is sampled.

## Test plan
- Reset, then L=2, T=3 with a model of the standard controller:
  - pipe_start at cycles 1, 12, 23, 34, 45, 56.
  - buf_sel=1 from cycle 34.
  - done at 67; cmd_ready high at 68.
- cmd_layers=0 (or cmd_tiles=0) with cmd_valid → err pulse at cycle 1, no pipe_start, cmd_ready stays 1.
- pipe_busy tied to 0, L=1, T=1 → pipe_start at 1, err at cycle 2+ACK_TIMEOUT (6 with the default), back in IDLE, no done.
- L=1, T=4, abort asserted in the second WAIT_DONE:
  - IDLE on the next edge, no done, no further pipe_start.
  - A new command is accepted right after.
- abort during an ISSUE cycle → no pipe_start pulse that cycle; IDLE next.
- rst asserted mid-command → every output returns to its reset value on the next edge. cmd_valid held high through the last reset cycle is then accepted in the first post-reset cycle.

Source files
------------

// File: rtl/layer_tile_sequencer.sv
// Network-pass scheduler: walks layers x tiles, pulses the pipeline controller once per tile,
// flips the weight ping-pong select at each layer boundary and flags missing acknowledges.
module layer_tile_sequencer #(
    parameter int LAYER_W     = 4,
    parameter int TILE_W      = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LAYER_W-1:0] cmd_layers,
    input  logic [TILE_W-1:0]  cmd_tiles,
    input  logic               abort,
    output logic               pipe_start,
    input  logic               pipe_busy,
    output logic               buf_sel,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t             state;
    logic [LAYER_W-1:0] layers_r;
    logic [TILE_W-1:0]  tiles_r;
    logic [ACK_W-1:0]   ack_cnt_r;

    // The start pulse must vanish in the very cycle abort or rst is seen, so it cannot be registered.
    assign pipe_start = (state == ISSUE) && !abort && !rst;

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            buf_sel   <= 1'b0;
            layer_idx <= {LAYER_W{1'b0}};
            tile_idx  <= {TILE_W{1'b0}};
            layers_r  <= {LAYER_W{1'b0}};
            tiles_r   <= {TILE_W{1'b0}};
            ack_cnt_r <= {ACK_W{1'b0}};
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if ((state != IDLE) && abort) begin
                state     <= IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            if ((cmd_layers == {LAYER_W{1'b0}}) || (cmd_tiles == {TILE_W{1'b0}})) begin
                                err <= 1'b1;
                            end else begin
                                layers_r  <= cmd_layers;
                                tiles_r   <= cmd_tiles;
                                layer_idx <= {LAYER_W{1'b0}};
                                tile_idx  <= {TILE_W{1'b0}};
                                buf_sel   <= 1'b0;
                                state     <= ISSUE;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        ack_cnt_r <= {ACK_W{1'b0}};
                        state     <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (pipe_busy) begin
                            state <= WAIT_DONE;
                        end else if (ack_cnt_r == ACK_W'(ACK_TIMEOUT - 1)) begin
                            err       <= 1'b1;
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            ack_cnt_r <= ack_cnt_r + ACK_W'(1);
                        end
                    end
                    WAIT_DONE: begin
                        if (!pipe_busy) begin
                            state <= ADVANCE;
                        end
                    end
                    // Bounds are checked before any increment, so the indices never wrap.
                    ADVANCE: begin
                        if (tile_idx != (tiles_r - TILE_W'(1))) begin
                            tile_idx <= tile_idx + TILE_W'(1);
                            state    <= ISSUE;
                        end else if (layer_idx != (layers_r - LAYER_W'(1))) begin
                            tile_idx  <= {TILE_W{1'b0}};
                            layer_idx <= layer_idx + LAYER_W'(1);
                            buf_sel   <= ~buf_sel;
                            state     <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_tile_sequencer.sv
// Directed bench for layer_tile_sequencer: cycle-accurate expectations counted from the accept cycle,
// with a model of the standard pipeline controller (busy for the 8 cycles after a start).
module tb_layer_tile_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_layers;
    logic [7:0] cmd_tiles;
    logic       abort;
    logic       pipe_start;
    logic       pipe_busy;
    logic       buf_sel;
    logic [3:0] layer_idx;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bcnt     = 0;
    bit model_en = 1'b1;

    layer_tile_sequencer #(.LAYER_W(4), .TILE_W(8), .ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_layers (cmd_layers),
        .cmd_tiles  (cmd_tiles),
        .abort      (abort),
        .pipe_start (pipe_start),
        .pipe_busy  (pipe_busy),
        .buf_sel    (buf_sel),
        .layer_idx  (layer_idx),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock; sample pipe_start just before the edge and update the controller model after it.
    task automatic tick();
        logic ps;
        #1;
        ps = pipe_start;
        @(posedge clk);
        #1;
        cyc++;
        if (model_en) begin
            if (ps) bcnt = 8;
            pipe_busy = (bcnt != 0);
            if (bcnt != 0) bcnt--;
        end
    endtask

    task automatic issue_cmd(input logic [3:0] l, input logic [7:0] t);
        cmd_valid  = 1'b1;
        cmd_layers = l;
        cmd_tiles  = t;
        cyc        = 0;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, cmd_ready, 1'b1);
        check_eq({tag, "_busy"},  busy,      1'b0);
        check_eq({tag, "_start"}, pipe_start, 1'b0);
        check_eq({tag, "_done"},  done,      1'b0);
        check_eq({tag, "_err"},   err,       1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_layers = 4'd0; cmd_tiles = 8'd0;
        abort = 1'b0; pipe_busy = 1'b0;
        repeat (3) tick();

        // Reset state
        check_idle_outputs("rst");
        check_eq("rst_bufsel", buf_sel, 1'b0);
        check_eq("rst_layer", layer_idx, 4'd0);
        check_eq("rst_tile", tile_idx, 8'd0);
        rst = 1'b0;

        // L=2, T=3 with the standard controller
        issue_cmd(4'd2, 8'd3);
        while (cyc <= 70) begin
            check_eq("t1_start", pipe_start, (cyc == 1 || cyc == 12 || cyc == 23 ||
                                             cyc == 34 || cyc == 45 || cyc == 56));
            check_eq("t1_done", done, (cyc == 67));
            check_eq("t1_ready", cmd_ready, (cyc >= 68));
            check_eq("t1_busy", busy, (cyc < 68));
            check_eq("t1_bufsel", buf_sel, (cyc >= 34));
            check_eq("t1_err", err, 1'b0);
            if (cyc == 12) begin
                check_eq("t1_tile_c12", tile_idx, 8'd1);
                check_eq("t1_layer_c12", layer_idx, 4'd0);
            end
            if (cyc == 34) begin
                check_eq("t1_tile_c34", tile_idx, 8'd0);
                check_eq("t1_layer_c34", layer_idx, 4'd1);
            end
            if (cyc == 68) begin
                check_eq("t1_tile_hold", tile_idx, 8'd2);
                check_eq("t1_layer_hold", layer_idx, 4'd1);
            end
            tick();
        end

        // Illegal commands: zero layers, then zero tiles
        for (int v = 0; v < 2; v++) begin
            issue_cmd((v == 0) ? 4'd0 : 4'd3, (v == 0) ? 8'd5 : 8'd0);
            check_eq("ill_err", err, 1'b1);
            check_eq("ill_start", pipe_start, 1'b0);
            check_eq("ill_ready", cmd_ready, 1'b1);
            check_eq("ill_busy", busy, 1'b0);
            tick();
            check_eq("ill_err_clear", err, 1'b0);
            check_eq("ill_start2", pipe_start, 1'b0);
        end

        // Ack timeout: controller never responds
        model_en = 1'b0; pipe_busy = 1'b0; bcnt = 0;
        issue_cmd(4'd1, 8'd1);
        while (cyc <= 8) begin
            check_eq("to_start", pipe_start, (cyc == 1));
            check_eq("to_err", err, (cyc == 6));
            check_eq("to_busy", busy, (cyc < 6));
            check_eq("to_ready", cmd_ready, (cyc >= 6));
            check_eq("to_done", done, 1'b0);
            tick();
        end
        model_en = 1'b1;

        // Abort in WAIT_DONE of the second tile, then an immediate new command
        issue_cmd(4'd1, 8'd4);
        while (cyc < 15) begin
            check_eq("ab_start", pipe_start, (cyc == 1 || cyc == 12));
            check_eq("ab_done", done, 1'b0);
            tick();
        end
        check_eq("ab_tile", tile_idx, 8'd1);
        check_eq("ab_busy_pre", busy, 1'b1);
        abort = 1'b1; bcnt = 0; pipe_busy = 1'b0;
        tick();
        abort = 1'b0;
        check_idle_outputs("ab_after");
        issue_cmd(4'd1, 8'd1);
        while (cyc <= 13) begin
            check_eq("ab_new_start", pipe_start, (cyc == 1));
            check_eq("ab_new_done", done, (cyc == 12));
            check_eq("ab_new_ready", cmd_ready, (cyc >= 13));
            tick();
        end

        // Abort during ISSUE suppresses the start pulse
        issue_cmd(4'd1, 8'd1);
        check_eq("ai_start_pre", pipe_start, 1'b1);
        abort = 1'b1;
        #1;
        check_eq("ai_start_supp", pipe_start, 1'b0);
        tick();
        abort = 1'b0;
        check_idle_outputs("ai_after");
        tick();
        check_eq("ai_start_none", pipe_start, 1'b0);

        // Reset mid-command with cmd_valid held across the last reset cycle
        issue_cmd(4'd2, 8'd3);
        while (cyc < 12) tick();
        check_eq("rs_tile_pre", tile_idx, 8'd1);
        rst = 1'b1; cmd_valid = 1'b1; cmd_layers = 4'd1; cmd_tiles = 8'd1;
        #1;
        check_eq("rs_start_drop", pipe_start, 1'b0);
        tick();
        check_idle_outputs("rs_after");
        check_eq("rs_tile", tile_idx, 8'd0);
        check_eq("rs_layer", layer_idx, 4'd0);
        check_eq("rs_bufsel", buf_sel, 1'b0);
        rst = 1'b0; bcnt = 0; pipe_busy = 1'b0;
        cyc = 0;
        tick();
        cmd_valid = 1'b0;
        while (cyc <= 13) begin
            check_eq("rs_new_start", pipe_start, (cyc == 1));
            check_eq("rs_new_done", done, (cyc == 12));
            check_eq("rs_new_ready", cmd_ready, (cyc >= 13));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
